// File: rtl/array_arbiter.sv
// -----------------------------------------------------------------------------
// array_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share a single-port word
// array of DEPTH x DATA_W bits. One read or write is granted per cycle. Read
// data comes back one cycle after the grant, tagged with the requester id.
// After reset, or when clear is pulsed while serving, a sweep zero-fills the
// whole array. No request is accepted until the sweep has finished.
//
// Optional feature macro: ARRAY_ARBITER_PARITY_EN
//   When defined, every stored word carries one extra even-parity bit. The
//   sweep stores parity 0 next to its zero data. A read recomputes the parity
//   and parity_err pulses together with rsp_valid on a mismatch.
//   When undefined, words are DATA_W bits wide and parity_err is tied to 0.
//   The port list is the same in both builds.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous, active-high reset
//   req_valid  in   [NUM_REQ]         per-requester request valid
//   req_ready  out  [NUM_REQ]         per-requester grant (one-hot or zero)
//   req_we     in   [NUM_REQ]         1 = write, 0 = read
//   req_addr   in   [NUM_REQ*ADDR_W]  requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   [NUM_REQ*DATA_W]  requester i at [i*DATA_W +: DATA_W]
//   clear      in   pulse that restarts the zero-fill sweep
//   init_done  out  high while the array is serving requests
//   rsp_valid  out  one-cycle pulse per granted read
//   rsp_id     out  [$clog2(NUM_REQ)] id of the requester that issued the read
//   rsp_rdata  out  [DATA_W]          read data; holds its last value otherwise
//   parity_err out  read parity mismatch, pulses with rsp_valid
//
// Handshake: a requester raises req_valid[i] and holds we/addr/wdata steady.
// The transfer happens on the rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready depends combinationally on req_valid,
// so a request can be granted in the same cycle it first appears. A requester
// may drop req_valid before it is granted; this withdraws the request.
// -----------------------------------------------------------------------------
module array_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 32,
   parameter  int DEPTH   = 256,
   localparam int ADDR_W  = $clog2(DEPTH),
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic                      clear,
   output logic                      init_done,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      parity_err
);

`ifdef ARRAY_ARBITER_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] sweep_q;
   logic [ID_W-1:0]   rr_q;

   // Arbitration
   logic [NUM_REQ-1:0] valid_rot;
   logic               grant_found;
   logic [ID_W-1:0]    grant_id;
   int                 scan_idx;
   logic               do_grant;

   // Request selected by the current grant
   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;

   // Storage port
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_waddr;
   logic [MEM_W-1:0]   mem_wdata;
   logic               rd_en;
   logic [MEM_W-1:0]   rd_word;
   logic [MEM_W-1:0]   mem [DEPTH];

   // --------------------------------------------------------------------------
   // Round-robin scan. The valid vector is rotated so that bit 0 is the
   // requester at the rr pointer. The first set bit at offset k is then
   // requester (rr + k) mod NUM_REQ.
   // --------------------------------------------------------------------------
   always_comb begin
      valid_rot   = NUM_REQ'({req_valid, req_valid} >> rr_q);
      grant_found = 1'b0;
      grant_id    = '0;
      scan_idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && valid_rot[k]) begin
            grant_found = 1'b1;
            scan_idx    = int'(rr_q) + k;
            if (scan_idx >= NUM_REQ) begin
               scan_idx = scan_idx - NUM_REQ;
            end
            grant_id = ID_W'(scan_idx);
         end
      end
   end

   // Pull the granted requester's fields out of the packed buses.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // --------------------------------------------------------------------------
   // FSM next state and outputs. A clear in SERVE blocks the grant for that
   // cycle, so no access races with the sweep that starts next cycle.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      do_grant  = 1'b0;
      req_ready = '0;
      init_done = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = sel_addr;
      mem_wdata = '0;
      rd_en     = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            // The sweep writes an all-zero word, parity bit included.
            mem_we    = 1'b1;
            mem_waddr = sweep_q;
            mem_wdata = '0;
            if (sweep_q == LAST_ADDR) begin
               state_d = ST_SERVE;
            end
         end
         ST_SERVE: begin
            init_done = 1'b1;
            if (clear) begin
               state_d = ST_CLEAR;
            end else if (grant_found) begin
               do_grant            = 1'b1;
               req_ready[grant_id] = 1'b1;
               mem_we              = sel_we;
               rd_en               = !sel_we;
`ifdef ARRAY_ARBITER_PARITY_EN
               mem_wdata = {^sel_wdata, sel_wdata};
`else
               mem_wdata = sel_wdata;
`endif
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // --------------------------------------------------------------------------
   // State, sweep address and round-robin pointer
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         sweep_q <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_CLEAR) begin
            // Wraps to zero after the last address, ready for the next clear.
            sweep_q <= sweep_q + 1'b1;
         end else if (clear) begin
            sweep_q <= '0;
         end
         if (do_grant) begin
            rr_q <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Storage. It has no reset: only the sweep gives it defined contents.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign rd_word = mem[sel_addr];

   // --------------------------------------------------------------------------
   // Read response. The word is captured at the grant edge. A write on the
   // previous edge is therefore already visible to the read.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= rd_en;
         if (rd_en) begin
            rsp_id    <= grant_id;
            rsp_rdata <= rd_word[DATA_W-1:0];
         end
      end
   end

`ifdef ARRAY_ARBITER_PARITY_EN
   // Even parity across data plus parity bit: an odd XOR means a mismatch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= rd_en && (^rd_word);
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_array_arbiter.sv
// -----------------------------------------------------------------------------
// tb_array_arbiter
//
// Directed bench for array_arbiter (4 requesters, 256 x 32).
// A reference model of the arbiter's rules runs alongside the DUT, and one
// compare process checks every DUT output against it each cycle. The driver
// also checks a set of hand-computed literal values. The bench ends with a
// single TB_RESULT line.
// -----------------------------------------------------------------------------
module tb_array_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;
   localparam int DEPTH   = 256;
   localparam int ADDR_W  = 8;
   localparam int ID_W    = 2;

   // ---------------------------------------------------------------- signals
   logic                      clk       = 1'b0;
   logic                      rst       = 1'b1;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_we    = '0;
   logic [NUM_REQ*ADDR_W-1:0] req_addr  = '0;
   logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
   logic                      clear     = 1'b0;
   logic                      init_done;
   logic                      rsp_valid;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      parity_err;

   int checks   = 0;
   int failures = 0;

   array_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .clear      (clear),
      .init_done  (init_done),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_rdata  (rsp_rdata),
      .parity_err (parity_err)
   );

   // ------------------------------------------------------------ clock block
   always #5 clk = ~clk;

   // ------------------------------------------------------------ check task
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------- reference model
   // Array contents, remaining sweep cycles (0 = serving), rr pointer, and the
   // expected response. Read data goes through the scoreboard queue exp_q.
   logic [DATA_W-1:0] m_mem [DEPTH];
   int                m_clr_left   = DEPTH;
   int                m_rr         = 0;
   logic              m_valid      = 1'b0;
   logic [ID_W-1:0]   m_id         = '0;
   logic              m_perr       = 1'b0;
   logic [DATA_W-1:0] m_last       = '0;
   logic              m_perr_on    = 1'b0;
   logic [ADDR_W-1:0] m_perr_addr  = '0;
   logic [DATA_W-1:0] exp_q[$];

   function automatic void model_reset();
      m_clr_left = DEPTH;
      m_rr       = 0;
      m_valid    = 1'b0;
      m_id       = '0;
      m_perr     = 1'b0;
      m_last     = '0;
      exp_q.delete();
   endfunction

   function automatic int model_grant(input logic [NUM_REQ-1:0] v);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (v[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   // -------------------------------------------------------- compare process
   initial begin : compare
      logic [NUM_REQ-1:0]        s_v;
      logic [NUM_REQ-1:0]        s_we;
      logic [NUM_REQ*ADDR_W-1:0] s_a;
      logic [NUM_REQ*DATA_W-1:0] s_d;
      logic                      s_clr;
      logic                      s_rst;
      logic [NUM_REQ-1:0]        e_ready;
      logic [ADDR_W-1:0]         a;
      int                        g;
      forever begin
         @(negedge clk);
         s_v   = req_valid;
         s_we  = req_we;
         s_a   = req_addr;
         s_d   = req_wdata;
         s_clr = clear;
         s_rst = rst;
         if (s_rst) model_reset();
         g = (s_rst || m_clr_left > 0 || s_clr) ? -1 : model_grant(s_v);
         e_ready = '0;
         if (g >= 0) e_ready[g] = 1'b1;
         check("m_req_ready", 64'(req_ready), 64'(e_ready));
         check("m_init_done", 64'(init_done), 64'(!s_rst && m_clr_left == 0));
         check("m_rsp_valid", 64'(rsp_valid), 64'(m_valid));
         check("m_parity_err", 64'(parity_err), 64'(m_perr));
         if (m_valid) begin
            check("m_rsp_id", 64'(rsp_id), 64'(m_id));
            if (exp_q.size() > 0) m_last = exp_q.pop_front();
         end
         check("m_rsp_rdata", 64'(rsp_rdata), 64'(m_last));

         @(posedge clk);
         m_valid = 1'b0;
         m_perr  = 1'b0;
         if (s_rst) begin
            model_reset();
         end else if (m_clr_left > 0) begin
            m_clr_left--;
            if (m_clr_left == 0) begin
               foreach (m_mem[i]) m_mem[i] = '0;
            end
         end else if (s_clr) begin
            m_clr_left = DEPTH;
         end else if (g >= 0) begin
            a    = s_a[g*ADDR_W +: ADDR_W];
            m_rr = (g + 1) % NUM_REQ;
            if (s_we[g]) begin
               m_mem[a] = s_d[g*DATA_W +: DATA_W];
               if (m_perr_on && a == m_perr_addr) m_perr_on = 1'b0;
            end else begin
               m_valid = 1'b1;
               m_id    = ID_W'(g);
               m_perr  = m_perr_on && (a == m_perr_addr);
               exp_q.push_back(m_mem[a]);
            end
         end
      end
   end

   // ------------------------------------------------------------ driver tasks
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int i, input logic v, input logic we,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_valid[i]                 = v;
      req_we[i]                    = we;
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_wdata[i*DATA_W +: DATA_W] = d;
   endtask

   // The next edge must be the first edge of the sweep.
   task automatic wait_sweep(input string tag);
      for (int c = 1; c <= DEPTH; c++) begin
         tick();
         if (c < DEPTH) check({tag, "_init_low"}, 64'(init_done), 64'(0));
         else           check({tag, "_init_high"}, 64'(init_done), 64'(1));
      end
   endtask

   // --------------------------------------------------- reset block + stimulus
   initial begin : driver
      logic [NUM_REQ-1:0] rdy;

      // Reset. Requester 2 already holds a read of 0x55.
      set_req(2, 1'b1, 1'b0, 8'h55, 32'h0);
      repeat (3) tick();
      check("rst_init_done", 64'(init_done), 64'(0));
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_id",    64'(rsp_id),    64'(0));
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      check("rst_parity",    64'(parity_err), 64'(0));
      rst = 1'b0;
      wait_sweep("boot");
      check("first_grant", 64'(req_ready), 64'(4'b0100));
      tick();
      req_valid[2] = 1'b0;
      #1;
      check("rd55_valid", 64'(rsp_valid), 64'(1));
      check("rd55_id",    64'(rsp_id),    64'(2));
      check("rd55_data",  64'(rsp_rdata), 64'(0));

      // Requester 1 writes 0x10, then reads it back on the next cycle.
      set_req(1, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
      #1 check("wr10_ready", 64'(req_ready), 64'(4'b0010));
      tick();
      set_req(1, 1'b1, 1'b0, 8'h10, 32'h0);
      #1 check("rd10_ready", 64'(req_ready), 64'(4'b0010));
      tick();
      req_valid[1] = 1'b0;
      #1;
      check("rd10_valid", 64'(rsp_valid), 64'(1));
      check("rd10_id",    64'(rsp_id),    64'(1));
      check("rd10_data",  64'(rsp_rdata), 64'(32'hDEADBEEF));

      // A lone read from requester 3 moves the pointer back to 0.
      set_req(3, 1'b1, 1'b0, 8'h00, 32'h0);
      #1 check("r3_ready", 64'(req_ready), 64'(4'b1000));
      tick();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 8'h10, 32'h0);
      for (int k = 0; k < 6; k++) begin
         #1;
         check("rr_grant",  64'(req_ready), 64'(1 << (k % 4)));
         check("rr_rsp_id", 64'(rsp_id),    64'((k + 3) % 4));
         tick();
      end
      req_valid = '0;
      #1 check("rr_last_data", 64'(rsp_rdata), 64'(32'hDEADBEEF));

      // Write 0x7 to 0xFF, read it, then pulse clear while the read returns.
      set_req(0, 1'b1, 1'b1, 8'hFF, 32'h7);
      #1 check("wrff_ready", 64'(req_ready), 64'(4'b0001));
      tick();
      set_req(0, 1'b1, 1'b0, 8'hFF, 32'h0);
      #1 check("rdff_ready", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid[0] = 1'b0;
      clear        = 1'b1;
      set_req(1, 1'b1, 1'b0, 8'hFF, 32'h0);
      #1;
      check("clr_rsp_valid", 64'(rsp_valid), 64'(1));
      check("clr_rsp_data",  64'(rsp_rdata), 64'(7));
      check("clr_no_grant",  64'(req_ready), 64'(0));
      tick();
      clear = 1'b0;
      wait_sweep("clear");
      check("post_clr_grant", 64'(req_ready), 64'(4'b0010));
      tick();
      req_valid[1] = 1'b0;
      #1;
      check("rdff_cleared_valid", 64'(rsp_valid), 64'(1));
      check("rdff_cleared_data",  64'(rsp_rdata), 64'(0));

      // A reset with a read response in flight drops it, then a reset mid-sweep.
      set_req(2, 1'b1, 1'b0, 8'h10, 32'h0);
      #1 check("rd_pre_rst_ready", 64'(req_ready), 64'(4'b0100));
      tick();
      req_valid = '0;
      rst       = 1'b1;
      #1;
      check("rst_drop_valid", 64'(rsp_valid), 64'(0));
      check("rst_drop_init",  64'(init_done), 64'(0));
      tick();
      rst = 1'b0;
      repeat (100) tick();
      rst = 1'b1;
      #1 check("mid_rst_init", 64'(init_done), 64'(0));
      tick();
      rst = 1'b0;
      wait_sweep("rst_mid");

      // Mixed traffic over a small address window. The model checks it.
      for (int n = 0; n < 300; n++) begin
         #1 rdy = req_ready;
         tick();
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rdy[i] || !req_valid[i]) begin
               set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 7)), $urandom());
            end
         end
      end
      req_valid = '0;
      tick();

`ifdef ARRAY_ARBITER_PARITY_EN
      // Flip one stored bit behind the arbiter's back.
      set_req(0, 1'b1, 1'b1, 8'h20, 32'h0);
      tick();
      req_valid[0] = 1'b0;
      dut.mem[8'h20][3] = ~dut.mem[8'h20][3];
      m_mem[8'h20][3]   = ~m_mem[8'h20][3];
      m_perr_addr       = 8'h20;
      m_perr_on         = 1'b1;
      set_req(0, 1'b1, 1'b0, 8'h20, 32'h0);
      tick();
      req_valid[0] = 1'b0;
      #1;
      check("perr_flip_valid", 64'(rsp_valid),  64'(1));
      check("perr_flip",       64'(parity_err), 64'(1));
      set_req(0, 1'b1, 1'b0, 8'h21, 32'h0);
      tick();
      req_valid[0] = 1'b0;
      #1 check("perr_clean", 64'(parity_err), 64'(0));
`endif

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------------------------------------------------------- watchdog
   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
